ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It is the opposite direction of the existing keyboard receiver path, and sends command bytes to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable. It drives the bidirectional ps2_clock/ps2_data pins through open-drain enables that the top level resolves. While it owns the bus, it raises rx_inhibit so the PS2 receiver and debouncer ignore edges.

---
 rtl/ps2_host_tx_pkg.sv | 25 ++
 rtl/ps2_host_tx_if.sv | 19 +
 rtl/ps2_host_tx_sync_edge.sv | 30 +++
 rtl/ps2_host_tx.sv | 182 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      WAIT_DEV,
      DATA,
      ACK,
      WAIT_IDLE,
      ERR
   } ps2_state_t;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] ACK_BYTE     = 8'hFA;

   // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between the host logic and the PS/2 transmitter.
interface ps2_host_tx_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_ack_err;
   logic       tx_timeout;

   modport master (
      output tx_valid, tx_data,
      input  tx_ready, tx_done, tx_ack_err, tx_timeout
   );

   modport slave (
      input  tx_valid, tx_data,
      output tx_ready, tx_done, tx_ack_err, tx_timeout
   );
endinterface

// File: rtl/ps2_host_tx_sync_edge.sv
// Multi-stage synchronizer for an asynchronous PS/2 line plus a falling-edge strobe.
// The chain resets to 1 because an idle PS/2 line floats high.
module ps2_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic resetn,
   input  logic line_in,
   output logic sync,
   output logic fe
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   // Shift the raw pin through the chain and keep the last synchronized level.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         chain <= '1;
         prev  <= 1'b1;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], line_in};
         prev  <= chain[SYNC_STAGES-1];
      end
   end

   assign sync = chain[SYNC_STAGES-1];
   assign fe   = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: requests the bus, shifts out one command byte
// on the device-generated clock and checks the device acknowledge.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | lines released, ready for a command byte
// INHIBIT   | holding ps2_clock low to request the bus
// REQ       | one cycle with clock and data both low (start bit)
// WAIT_DEV  | clock released, data low, waiting for first device falling edge
// DATA      | shifting data bits then parity, releasing data for the stop bit
// ACK       | sampling the device acknowledge on the 11th falling edge
// WAIT_IDLE | waiting for the device to release both lines
// ERR       | lines released, error pulse for one cycle
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 6000,
   parameter int START_TIMEOUT  = 750000,
   parameter int PACKET_TIMEOUT = 100000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic        clock,
   input  logic        resetn,
   ps2_host_tx_if.slave host,
   input  logic        ps2_clk_in,
   input  logic        ps2_data_in,
   output logic        ps2_clk_oe,
   output logic        ps2_data_oe,
   output logic        rx_inhibit
);

   localparam int MAX_AB  = (START_TIMEOUT > PACKET_TIMEOUT) ? START_TIMEOUT : PACKET_TIMEOUT;
   localparam int CNT_MAX = (MAX_AB > INHIBIT_CYCLES) ? MAX_AB : INHIBIT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // Counter loads are terminal-count minus one so a state lasts exactly N cycles.
   localparam logic [CNT_W-1:0] INH_LOAD   = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] PKT_LOAD   = CNT_W'(PACKET_TIMEOUT - 1);

   ps2_state_t             state, state_next;
   logic [CNT_W-1:0]       cnt;
   logic                   cnt_zero;
   logic [7:0]             data_q;
   logic                   par_q;
   logic [3:0]             bit_idx;
   logic                   clk_sync, clk_fe, data_sync;
   logic [SYNC_STAGES-1:0] data_chain;
   logic                   err_is_ack;
   logic                   clk_oe_d, data_oe_d, done_d, ack_err_d, timeout_d;

   ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
      .clock   (clock),
      .resetn  (resetn),
      .line_in (ps2_clk_in),
      .sync    (clk_sync),
      .fe      (clk_fe)
   );

   // Data line only needs its level, so it gets a bare synchronizer chain.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) data_chain <= '1;
      else         data_chain <= {data_chain[SYNC_STAGES-2:0], ps2_data_in};
   end

   assign data_sync = data_chain[SYNC_STAGES-1];
   assign cnt_zero  = (cnt == '0);

   // State register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   // Next-state decode; device edges take priority over a coincident timeout.
   always_comb begin
      state_next = state;
      err_is_ack = 1'b0;
      unique case (state)
         IDLE:      if (host.tx_valid) state_next = INHIBIT;
         INHIBIT:   if (cnt_zero) state_next = REQ;
         REQ:       state_next = WAIT_DEV;
         WAIT_DEV: begin
            if (clk_fe)        state_next = DATA;
            else if (cnt_zero) state_next = ERR;
         end
         DATA: begin
            if (clk_fe) begin
               if (bit_idx == 4'd9) state_next = ACK;
            end else if (cnt_zero) begin
               state_next = ERR;
            end
         end
         ACK: begin
            if (clk_fe) begin
               if (data_sync) begin
                  state_next = ERR;
                  err_is_ack = 1'b1;
               end else begin
                  state_next = WAIT_IDLE;
               end
            end else if (cnt_zero) begin
               state_next = ERR;
            end
         end
         WAIT_IDLE: begin
            if (clk_sync && data_sync) state_next = IDLE;
            else if (cnt_zero)         state_next = ERR;
         end
         ERR:       state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // Byte capture, bit index and the shared saturating down-counter.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cnt     <= '0;
         data_q  <= '0;
         par_q   <= 1'b0;
         bit_idx <= '0;
      end else begin
         if (state == IDLE && host.tx_valid) begin
            data_q <= host.tx_data;
            par_q  <= odd_parity(host.tx_data);
         end

         // The packet budget keeps running from DATA into ACK; WAIT_IDLE gets a fresh one.
         if (state_next != state && state_next == INHIBIT)        cnt <= INH_LOAD;
         else if (state_next != state && state_next == WAIT_DEV)  cnt <= START_LOAD;
         else if (state_next != state && state_next == DATA)      cnt <= PKT_LOAD;
         else if (state_next != state && state_next == WAIT_IDLE) cnt <= PKT_LOAD;
         else if (!cnt_zero)                                      cnt <= cnt - 1'b1;

         if (state == WAIT_DEV && clk_fe)  bit_idx <= 4'd1;
         else if (state == DATA && clk_fe) bit_idx <= bit_idx + 4'd1;
      end
   end

   // Output decode from the upcoming state so the pin enables can be registered.
   always_comb begin
      clk_oe_d  = (state_next == INHIBIT) || (state_next == REQ);
      data_oe_d = 1'b0;
      done_d    = (state == WAIT_IDLE) && (state_next == IDLE);
      ack_err_d = (state_next == ERR) && err_is_ack;
      timeout_d = (state_next == ERR) && !err_is_ack;
      unique case (state_next)
         REQ, WAIT_DEV: data_oe_d = 1'b1;
         DATA: begin
            if (clk_fe) begin
               if (state == WAIT_DEV)     data_oe_d = ~data_q[0];
               else if (bit_idx < 4'd8)   data_oe_d = ~data_q[bit_idx[2:0]];
               else                       data_oe_d = ~par_q;
            end else begin
               data_oe_d = ps2_data_oe;
            end
         end
         default: data_oe_d = 1'b0;
      endcase
   end

   // Registered pin enables and completion pulses.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ps2_clk_oe      <= 1'b0;
         ps2_data_oe     <= 1'b0;
         host.tx_done    <= 1'b0;
         host.tx_ack_err <= 1'b0;
         host.tx_timeout <= 1'b0;
      end else begin
         ps2_clk_oe      <= clk_oe_d;
         ps2_data_oe     <= data_oe_d;
         host.tx_done    <= done_d;
         host.tx_ack_err <= ack_err_d;
         host.tx_timeout <= timeout_d;
      end
   end

   assign host.tx_ready = (state == IDLE);
   assign rx_inhibit    = (state != IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device and a frame scoreboard.
module tb_ps2_host_tx;

   logic clock  = 1'b0;
   logic resetn = 1'b0;
   always #5 clock = ~clock;

   ps2_host_tx_if host();

   logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe, rx_inhibit;
   logic dev_clk_low  = 1'b0;
   logic dev_data_low = 1'b0;

   // Open-drain bus resolution: either side pulling low wins.
   assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES (20),
      .START_TIMEOUT  (500),
      .PACKET_TIMEOUT (2000),
      .SYNC_STAGES    (2)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .host        (host),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .rx_inhibit  (rx_inhibit)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int n_done = 0, n_ackerr = 0, n_tmo = 0, n_inh = 0, n_rx_bad = 0;

   always @(negedge clock) begin
      if (host.tx_done)                   n_done++;
      if (host.tx_ack_err)                n_ackerr++;
      if (host.tx_timeout)                n_tmo++;
      if (ps2_clk_oe && !ps2_data_oe)     n_inh++;
      if (!host.tx_ready && !rx_inhibit)  n_rx_bad++;
   end

   logic [9:0] sb_q[$];

   // Expected device view: {stop, parity, data}, parity chosen so the ones count is odd.
   function automatic logic [9:0] model_frame(input logic [7:0] b);
      int ones = 0;
      for (int i = 0; i < 8; i++) if (b[i]) ones++;
      return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send(input logic [7:0] b, input bit expect_delivery);
      @(negedge clock);
      check($sformatf("ready_before_%02h", b), host.tx_ready, 1);
      host.tx_valid = 1'b1;
      host.tx_data  = b;
      if (expect_delivery) sb_q.push_back(model_frame(b));
      @(negedge clock);
      host.tx_valid = 1'b0;
   endtask

   // Device side: waits for the host request, clocks 10 bits in, then the ack pulse.
   task automatic dev_rx(input bit ack_low, output logic start_bit,
                         output logic [9:0] frame, output bit ok);
      bit found = 1'b0;
      ok        = 1'b0;
      frame     = '0;
      start_bit = 1'b1;
      for (int w = 0; w < 400; w++) begin
         @(negedge clock);
         if (!ps2_clk_oe && ps2_data_oe) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) return;
      start_bit = ps2_data_in;
      cycles(5);
      for (int i = 0; i < 10; i++) begin
         dev_clk_low = 1'b1;
         cycles(20);
         dev_clk_low = 1'b0;
         frame[i] = ps2_data_in;
         cycles(20);
      end
      dev_data_low = ack_low;
      cycles(5);
      dev_clk_low = 1'b1;
      cycles(20);
      dev_clk_low = 1'b0;
      cycles(5);
      dev_data_low = 1'b0;
      ok = 1'b1;
   endtask

   // One full transfer; kind 1 = done expected, 2 = ack error expected.
   task automatic xfer(input logic [7:0] b, input bit ack_low, input int kind, input bit inject);
      int d0, a0, t0, i0;
      logic st;
      logic [9:0] fr;
      logic [9:0] exp_fr;
      bit ok;
      d0 = n_done; a0 = n_ackerr; t0 = n_tmo; i0 = n_inh;
      send(b, 1'b1);
      fork
         dev_rx(ack_low, st, fr, ok);
         begin
            if (inject) begin
               cycles(200);
               check("busy_ready_low", host.tx_ready, 0);
               check("busy_rx_inhibit", rx_inhibit, 1);
               host.tx_valid = 1'b1;
               host.tx_data  = 8'hFF;
               cycles(3);
               host.tx_valid = 1'b0;
            end
         end
      join
      check($sformatf("dev_saw_request_%02h", b), ok, 1);
      check($sformatf("start_bit_%02h", b), st, 0);
      check($sformatf("sb_nonempty_%02h", b), sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
         exp_fr = sb_q.pop_front();
         check($sformatf("frame_%02h", b), fr, exp_fr);
      end
      for (int w = 0; w < 200 && !host.tx_ready; w++) @(negedge clock);
      cycles(3);
      check($sformatf("ready_return_%02h", b), host.tx_ready, 1);
      check($sformatf("lines_released_%02h", b), {ps2_clk_oe, ps2_data_oe}, 2'b00);
      check($sformatf("inhibit_len_%02h", b), n_inh - i0, 20);
      check($sformatf("done_delta_%02h", b), n_done - d0, (kind == 1) ? 1 : 0);
      check($sformatf("ackerr_delta_%02h", b), n_ackerr - a0, (kind == 2) ? 1 : 0);
      check($sformatf("timeout_delta_%02h", b), n_tmo - t0, 0);
   endtask

   initial begin
      int d0, a0, t0, n;
      bit found;
      host.tx_valid = 1'b0;
      host.tx_data  = 8'h00;
      resetn        = 1'b0;
      cycles(5);
      check("rst_ready", host.tx_ready, 1);
      check("rst_clk_oe", ps2_clk_oe, 0);
      check("rst_data_oe", ps2_data_oe, 0);
      check("rst_rx_inhibit", rx_inhibit, 0);
      check("rst_pulses", {host.tx_done, host.tx_ack_err, host.tx_timeout}, 3'b000);
      resetn = 1'b1;
      cycles(5);

      xfer(ps2_pkg::CMD_SET_LEDS, 1'b1, 1, 1'b0);
      xfer(8'h01, 1'b1, 1, 1'b0);
      xfer(8'h00, 1'b1, 1, 1'b0);

      // Silent device: START timeout measured from the end of REQ.
      d0 = n_done; a0 = n_ackerr; t0 = n_tmo;
      send(8'h12, 1'b0);
      found = 1'b0;
      for (int w = 0; w < 100; w++) begin
         if (ps2_clk_oe) begin found = 1'b1; break; end
         @(negedge clock);
      end
      check("tmo_req_seen", found, 1);
      found = 1'b0;
      for (int w = 0; w < 100; w++) begin
         @(negedge clock);
         if (!ps2_clk_oe) begin found = 1'b1; break; end
      end
      check("tmo_req_end", found, 1);
      n = 0;
      for (int w = 0; w < 1000; w++) begin
         @(negedge clock);
         n++;
         if (host.tx_timeout) break;
      end
      check("tmo_latency", n, 500);
      check("tmo_lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      cycles(3);
      check("tmo_ready", host.tx_ready, 1);
      check("tmo_deltas", {n_done - d0, n_ackerr - a0, n_tmo - t0}, {32'd0, 32'd0, 32'd1});

      // Device withholds the acknowledge.
      xfer(ps2_pkg::ACK_BYTE, 1'b0, 2, 1'b0);

      // Stray request while busy must be dropped.
      xfer(ps2_pkg::CMD_ENABLE, 1'b1, 1, 1'b1);
      cycles(30);
      check("no_stray_accept", {host.tx_ready, ps2_clk_oe}, 2'b10);

      // Reset in the middle of a frame.
      d0 = n_done; a0 = n_ackerr; t0 = n_tmo;
      send(8'h5A, 1'b0);
      found = 1'b0;
      for (int w = 0; w < 400; w++) begin
         @(negedge clock);
         if (!ps2_clk_oe && ps2_data_oe) begin found = 1'b1; break; end
      end
      check("rstmid_req_seen", found, 1);
      cycles(5);
      for (int i = 0; i < 4; i++) begin
         dev_clk_low = 1'b1;
         cycles(20);
         dev_clk_low = 1'b0;
         cycles(20);
      end
      dev_clk_low = 1'b1;
      cycles(10);
      check("rstmid_busy", host.tx_ready, 0);
      resetn = 1'b0;
      #1;
      check("rstmid_clk_oe", ps2_clk_oe, 0);
      check("rstmid_data_oe", ps2_data_oe, 0);
      check("rstmid_ready", host.tx_ready, 1);
      check("rstmid_rx_inhibit", rx_inhibit, 0);
      dev_clk_low = 1'b0;
      cycles(3);
      resetn = 1'b1;
      cycles(3);
      check("rstmid_no_pulse", {n_done - d0, n_ackerr - a0, n_tmo - t0}, {32'd0, 32'd0, 32'd0});

      xfer(ps2_pkg::CMD_RESET, 1'b1, 1, 1'b0);

      check("total_done", n_done, 5);
      check("total_ack_err", n_ackerr, 1);
      check("total_timeout", n_tmo, 1);
      check("rx_inhibit_busy", n_rx_bad, 0);
      check("sb_drained", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
